branch_predictor: RTL

//  Direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters.

---
 rtl/branch_predictor.sv | 114 +++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Combinational lookup on the fetch PC, registered training from execute, wrapping mispredict count.
module branch_predictor #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ENTRIES    = 16,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_btb,
    input  logic [DATA_WIDTH-1:0] fetch_pc,
    output logic                  predict_valid,
    output logic                  predict_taken,
    output logic [DATA_WIDTH-1:0] predict_target,
    input  logic                  upd_en,
    input  logic [DATA_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic [DATA_WIDTH-1:0] upd_target,
    input  logic                  upd_mispredict,
    output logic [CNT_W-1:0]      mispredict_count
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = DATA_WIDTH - IDX_W - 2;

    localparam logic [1:0] CntWeakNt  = 2'b01;
    localparam logic [1:0] CntWeakTkn = 2'b10;

    logic [ENTRIES-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0]      tag_q    [ENTRIES];
    logic [TAG_W-1:0]      tag_d    [ENTRIES];
    logic [DATA_WIDTH-1:0] target_q [ENTRIES];
    logic [DATA_WIDTH-1:0] target_d [ENTRIES];
    logic [1:0]            cnt_q    [ENTRIES];
    logic [1:0]            cnt_d    [ENTRIES];
    logic [CNT_W-1:0]      mispredict_count_q, mispredict_count_d;

    logic [IDX_W-1:0] fetch_idx, upd_idx;
    logic [TAG_W-1:0] fetch_tag, upd_tag;
    logic             fetch_hit, upd_hit;

    assign fetch_idx = fetch_pc[IDX_W+1:2];
    assign fetch_tag = fetch_pc[DATA_WIDTH-1:IDX_W+2];
    assign upd_idx   = upd_pc[IDX_W+1:2];
    assign upd_tag   = upd_pc[DATA_WIDTH-1:IDX_W+2];

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    always_comb begin
        fetch_hit      = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
        predict_valid  = fetch_hit;
        predict_taken  = fetch_hit && cnt_q[fetch_idx][1];
        predict_target = fetch_hit ? target_q[fetch_idx] : '0;
    end

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

        if (flush_btb) begin
            valid_d = '0;
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_d[i] = CntWeakNt;
            end
        end else if (upd_en) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    target_d[upd_idx] = upd_target;
                    if (cnt_q[upd_idx] != 2'b11) begin
                        cnt_d[upd_idx] = cnt_q[upd_idx] + 2'd1;
                    end
                end else if (cnt_q[upd_idx] != 2'b00) begin
                    cnt_d[upd_idx] = cnt_q[upd_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target;
                cnt_d[upd_idx]    = CntWeakTkn;
            end
        end
    end

    // Counting is independent of flush so perf numbers survive BTB invalidation.
    always_comb begin
        mispredict_count_d = mispredict_count_q;
        if (upd_en && upd_mispredict) begin
            mispredict_count_d = mispredict_count_q + CNT_W'(1);
        end
    end

    assign mispredict_count = mispredict_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q            <= '0;
            mispredict_count_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CntWeakNt;
            end
        end else begin
            valid_q            <= valid_d;
            tag_q              <= tag_d;
            target_q           <= target_d;
            cnt_q              <= cnt_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

endmodule
